// File: rtl/note_recorder.sv
// Run-length encodes the live (note, pitch) sample taken on each beat pulse into
// (note, pitch, beat) entries and streams them into the song RAM write port.
module note_recorder #(
  parameter int AW       = 10,
  parameter int DEPTH    = 1023,
  parameter int MAX_BEAT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    note,
  input  logic [4:0]    pitchshift,
  input  logic          rec_en,
  input  logic          pulse,
  input  logic          clear,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [9:0]    wr_note,
  output logic [4:0]    wr_pit,
  output logic [3:0]    wr_beat,
  output logic [AW-1:0] rec_len,
  output logic          recording,
  output logic          full
);

  typedef enum logic [2:0] {IDLE, ARM, RUN, FLUSH, DONE} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [3:0]    BEAT_MAX  = 4'(MAX_BEAT);

  state_t     state;
  logic [9:0] cur_note;
  logic [4:0] cur_pit;
  logic [3:0] cnt;
  logic       extend;
  logic       close_entry;

  // A sample extends the open entry only if it matches and the beat field has room.
  function automatic logic extends_entry(input logic [9:0] n, input logic [4:0] p,
                                         input logic [9:0] cn, input logic [4:0] cp,
                                         input logic [3:0] c);
    return (n == cn) && (p == cp) && (c < BEAT_MAX);
  endfunction

  always_comb begin
    extend      = extends_entry(note, pitchshift, cur_note, cur_pit, cnt);
    close_entry = 1'b0;
    if (!clear) begin
      if (state == FLUSH)
        close_entry = 1'b1;
      else if (state == RUN && rec_en && pulse && !extend)
        close_entry = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_note  <= '0;
      cur_pit   <= '0;
      cnt       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_note   <= '0;
      wr_pit    <= '0;
      wr_beat   <= '0;
      rec_len   <= '0;
      recording <= 1'b0;
      full      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        rec_len   <= '0;
        full      <= 1'b0;
        wr_addr   <= '0;
        recording <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rec_en) begin
              state     <= ARM;
              wr_addr   <= '0;
              rec_len   <= '0;
              full      <= 1'b0;
              recording <= 1'b1;
            end
          end
          ARM: begin
            if (!rec_en) begin
              state     <= IDLE;
              recording <= 1'b0;
            end else if (pulse) begin
              cur_note <= note;
              cur_pit  <= pitchshift;
              cnt      <= 4'd1;
              state    <= RUN;
            end
          end
          RUN: begin
            // Dropping rec_en wins over a coincident pulse.
            if (!rec_en) begin
              state     <= FLUSH;
              recording <= 1'b0;
            end else if (pulse) begin
              if (extend) begin
                cnt <= cnt + 4'd1;
              end else begin
                cur_note <= note;
                cur_pit  <= pitchshift;
                cnt      <= 4'd1;
              end
            end
          end
          FLUSH: state <= DONE;
          DONE: begin
            if (!rec_en) state <= IDLE;
          end
          default: begin
            state     <= IDLE;
            recording <= 1'b0;
          end
        endcase

        if (close_entry) begin
          wr_en   <= 1'b1;
          wr_addr <= rec_len;
          wr_note <= cur_note;
          wr_pit  <= cur_pit;
          wr_beat <= cnt;
          rec_len <= rec_len + 1'b1;
          // Last slot written: stop for good, any pending sample is dropped.
          if (rec_len == LAST_ADDR) begin
            full      <= 1'b1;
            state     <= DONE;
            recording <= 1'b0;
          end
        end
      end
    end
  end

endmodule
